// File: rtl/key_search_scheduler.sv
// key_search_scheduler: hands out candidate RC4 keys to a pool of arcfour
// cores one at a time. The first reported success stops the search. If no
// core succeeds, the search ends once the whole key range has been tried.
module key_search_scheduler #(
  parameter int unsigned         NUM_CORES = 4,
  parameter int unsigned         KEY_BITS  = 24,
  parameter logic [KEY_BITS-1:0] KEY_LOWER = '0,
  parameter logic [KEY_BITS-1:0] KEY_UPPER = '1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic [NUM_CORES-1:0]          core_start,
  output logic [NUM_CORES*KEY_BITS-1:0] core_key,
  output logic                          core_abort,
  input  logic [NUM_CORES-1:0]          core_done,
  input  logic [NUM_CORES-1:0]          core_success,
  output logic                          busy,
  output logic                          done,
  output logic                          found,
  output logic [KEY_BITS-1:0]           found_key,
  output logic [KEY_BITS:0]             keys_tried
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RUN       = 3'd1;
  localparam logic [2:0] S_DRAIN     = 3'd2;
  localparam logic [2:0] S_FOUND     = 3'd3;
  localparam logic [2:0] S_EXHAUSTED = 3'd4;

  logic [2:0]           state;
  logic [NUM_CORES-1:0] core_busy;
  logic [NUM_CORES-1:0] accepted;
  logic [NUM_CORES-1:0] hit;
  logic [NUM_CORES-1:0] disp_oh;
  logic [KEY_BITS-1:0]  next_key;
  logic [KEY_BITS-1:0]  hit_key;
  logic [KEY_BITS:0]    accepted_cnt;
  logic                 last_issued;
  logic                 searching;
  logic                 have_idle;
  logic                 have_hit;
  logic                 any_hit;
  logic                 launch;

  assign searching = (state == S_RUN) || (state == S_DRAIN);
  assign busy      = searching;
  // A done from a core that holds no key is stale or spurious and is dropped.
  assign accepted  = searching ? (core_done & core_busy) : '0;
  assign hit       = accepted & core_success;
  assign any_hit   = |hit;
  // Dispatch uses the registered busy vector, so a core freed at this edge
  // only becomes eligible in the following cycle. A success cancels dispatch.
  assign launch    = (state == S_RUN) && have_idle && !any_hit;

  // Pick the lowest idle core and the lowest successful core, and count the accepted dones.
  always_comb begin
    disp_oh      = '0;
    hit_key      = '0;
    accepted_cnt = '0;
    have_idle    = 1'b0;
    have_hit     = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!core_busy[i] && !have_idle) begin
        disp_oh[i] = 1'b1;
        have_idle  = 1'b1;
      end
      if (hit[i] && !have_hit) begin
        hit_key  = core_key[i*KEY_BITS +: KEY_BITS];
        have_hit = 1'b1;
      end
      accepted_cnt = accepted_cnt + {{KEY_BITS{1'b0}}, accepted[i]};
    end
  end

  // Search control: state, dispatch, completion tracking and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      core_busy   <= '0;
      next_key    <= KEY_LOWER;
      last_issued <= 1'b0;
      core_start  <= '0;
      core_key    <= '0;
      core_abort  <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      found_key   <= '0;
      keys_tried  <= '0;
    end else begin
      core_start <= '0;
      core_abort <= 1'b0;
      case (state)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (start) begin
            next_key    <= KEY_LOWER;
            last_issued <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            found_key   <= '0;
            keys_tried  <= '0;
            core_busy   <= '0;
            state       <= S_RUN;
          end
        end
        S_RUN, S_DRAIN: begin
          keys_tried <= keys_tried + accepted_cnt;
          if (any_hit) begin
            found_key  <= hit_key;
            found      <= 1'b1;
            done       <= 1'b1;
            core_abort <= 1'b1;
            core_busy  <= '0;
            state      <= S_FOUND;
          end else if ((state == S_DRAIN) && last_issued && (core_busy == '0)) begin
            done  <= 1'b1;
            state <= S_EXHAUSTED;
          end else begin
            core_busy <= (core_busy & ~accepted) | (launch ? disp_oh : '0);
            if (launch) begin
              core_start <= disp_oh;
              for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (disp_oh[i]) core_key[i*KEY_BITS +: KEY_BITS] <= next_key;
              end
              // Stop at the upper bound instead of incrementing, so the key never wraps.
              if (next_key == KEY_UPPER) begin
                last_issued <= 1'b1;
                state       <= S_DRAIN;
              end else begin
                next_key <= next_key + KEY_BITS'(1);
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
